// File: rtl/datapath_if.sv
// datapath_if: control-unit to datapath bundle (decoded controls in, acc/register/flags out)
interface datapath_if;
  logic [2:0] mode;
  logic [1:0] select;
  logic       rf_we;
  logic       acc_we;
  logic       alu_mux;
  logic       alu_out_mux;
  logic       rf_mux;
  logic       data_imm;
  logic [7:0] imm;
  logic [7:0] acc_out;
  logic [7:0] rf_rd;
  logic       zero;
  logic       carry;
  modport master (
    output mode, select, rf_we, acc_we, alu_mux, alu_out_mux, rf_mux, data_imm, imm,
    input  acc_out, rf_rd, zero, carry
  );
  modport slave (
    input  mode, select, rf_we, acc_we, alu_mux, alu_out_mux, rf_mux, data_imm, imm,
    output acc_out, rf_rd, zero, carry
  );
endinterface

// File: rtl/datapath.sv
// datapath: 4x8 register file, 8-bit accumulator, ALU and zero/carry flags
module datapath (
  input logic       dp_clk,
  input logic       dp_rst_n,
  datapath_if.slave bus
);
  logic [7:0] rf [4];
  logic [7:0] acc, rd, b;
  logic [8:0] res;
  logic       zero, carry;
  assign rd = rf[bus.select];
  assign b  = bus.alu_mux ? rd : bus.imm;
  // bit 8 is carry for add and borrow for sub/compare
  always_comb
    res = bus.mode == 3'd0 ? {1'b0, acc} + {1'b0, b} :
          bus.mode == 3'd1 || bus.mode == 3'd2 ? {1'b0, acc} - {1'b0, b} :
          bus.mode == 3'd3 ? {1'b0, acc & b} :
          bus.mode == 3'd4 ? {1'b0, acc | b} :
          bus.mode == 3'd5 ? {1'b0, acc ^ b} :
          bus.mode == 3'd7 ? {1'b0, b} : {1'b0, acc};
  always_ff @(posedge dp_clk or negedge dp_rst_n)
    if (!dp_rst_n) begin
      rf    <= '{default: '0};
      acc   <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else begin
      if (bus.rf_we && (bus.data_imm || bus.rf_mux))
        rf[bus.select] <= bus.data_imm ? bus.imm : acc;
      if (bus.acc_we) begin
        if (bus.alu_out_mux)
          acc <= rd;
        else begin
          if (bus.mode != 3'd2 && bus.mode != 3'd6)
            acc <= res[7:0];
          if (bus.mode <= 3'd5) begin
            zero  <= res[7:0] == 8'h00;
            carry <= res[8];
          end
        end
      end
    end
  assign bus.acc_out = acc;
  assign bus.rf_rd   = rd;
  assign bus.zero    = zero;
  assign bus.carry   = carry;
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed vectors with hand-computed expectations for datapath
module tb_datapath;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;
  datapath_if bus ();
  datapath dut (.dp_clk(clk), .dp_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go;
    @(posedge clk);
    #1;
    bus.rf_we = 0; bus.acc_we = 0; bus.alu_out_mux = 0; bus.rf_mux = 0;
    bus.data_imm = 0; bus.alu_mux = 0; bus.mode = 0;
  endtask
  task automatic mi(input logic [1:0] r, input logic [7:0] v);
    bus.select = r; bus.imm = v; bus.data_imm = 1; bus.rf_we = 1; go;
  endtask
  task automatic ld(input logic [1:0] r);
    bus.select = r; bus.acc_we = 1; bus.alu_out_mux = 1; go;
  endtask
  task automatic op_rf(input logic [2:0] m, input logic [1:0] r);
    bus.select = r; bus.mode = m; bus.alu_mux = 1; bus.acc_we = 1; go;
  endtask
  task automatic op_imm(input logic [2:0] m, input logic [7:0] v);
    bus.imm = v; bus.mode = m; bus.alu_mux = 0; bus.acc_we = 1; go;
  endtask
  task automatic wb(input logic [1:0] r);
    bus.select = r; bus.rf_mux = 1; bus.rf_we = 1; go;
  endtask
  task automatic check_rf(input string tag, input logic [1:0] r, input logic [7:0] exp);
    bus.select = r;
    #1;
    check(tag, bus.rf_rd, exp);
  endtask
  task automatic check_flags(input string tag, input logic z, input logic c);
    check({tag, "_zero"}, {7'b0, bus.zero}, {7'b0, z});
    check({tag, "_carry"}, {7'b0, bus.carry}, {7'b0, c});
  endtask
  initial begin
    bus.mode = 0; bus.select = 0; bus.rf_we = 0; bus.acc_we = 0; bus.alu_mux = 0;
    bus.alu_out_mux = 0; bus.rf_mux = 0; bus.data_imm = 0; bus.imm = 0;
    #1;
    check("por_acc", bus.acc_out, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    go;
    // dirty every piece of state, then reset mid-cycle
    mi(0, 8'h55); mi(3, 8'h3C);
    op_imm(3'd7, 8'hFF);
    op_imm(3'd0, 8'h01);
    check("add_wrap_acc", bus.acc_out, 8'h00);
    check_flags("add_wrap", 1, 1);
    op_imm(3'd7, 8'h77);
    bus.select = 0;
    #2;
    rst_n = 0;
    #1;
    check("rst_acc", bus.acc_out, 8'h00);
    check("rst_rf_rd", bus.rf_rd, 8'h00);
    check_flags("rst", 0, 0);
    for (int i = 0; i < 4; i++) check_rf($sformatf("rst_r%0d", i), i[1:0], 8'h00);
    @(negedge clk) rst_n = 1;
    go;
    // immediate moves and a 3-edge register-register add
    mi(1, 8'h0F); mi(2, 8'hF1);
    check_rf("mi_r1", 1, 8'h0F);
    check_rf("mi_r2", 2, 8'hF1);
    ld(1);
    op_rf(3'd0, 2);
    wb(1);
    check_rf("add_r1", 1, 8'h00);
    check_flags("add", 1, 1);
    // sub, then compare after priming flags to the opposite values
    op_imm(3'd7, 8'h05); mi(3, 8'h07);
    op_rf(3'd1, 3);
    check("sub_acc", bus.acc_out, 8'hFE);
    check_flags("sub", 0, 1);
    op_imm(3'd7, 8'h00); op_imm(3'd0, 8'h00);
    check_flags("prime", 1, 0);
    op_imm(3'd7, 8'h05);
    op_rf(3'd2, 3);
    check("cmp_acc", bus.acc_out, 8'h05);
    check_flags("cmp", 0, 1);
    // logic ops, carry enters the first one set
    mi(0, 8'hAA);
    op_imm(3'd7, 8'hCC); op_rf(3'd3, 0);
    check("and_acc", bus.acc_out, 8'h88);
    check_flags("and", 0, 0);
    op_imm(3'd7, 8'hCC); op_rf(3'd4, 0);
    check("or_acc", bus.acc_out, 8'hEE);
    op_imm(3'd7, 8'hCC); op_rf(3'd5, 0);
    check("xor_acc", bus.acc_out, 8'h66);
    check_flags("xor", 0, 0);
    op_imm(3'd7, 8'hAA); op_rf(3'd5, 0);
    check("xor_self_acc", bus.acc_out, 8'h00);
    check_flags("xor_self", 1, 0);
    // simultaneous register writeback and accumulator load
    op_imm(3'd7, 8'h11); mi(2, 8'h22);
    bus.select = 2; bus.rf_we = 1; bus.rf_mux = 1; bus.acc_we = 1; bus.alu_out_mux = 1;
    go;
    check("sim_acc", bus.acc_out, 8'h22);
    check_rf("sim_r2", 2, 8'h11);
    // suppressed write, then data_imm priority over rf_mux
    bus.select = 2; bus.imm = 8'h99; bus.rf_we = 1;
    go;
    check_rf("supp_r2", 2, 8'h11);
    bus.select = 1; bus.imm = 8'h5A; bus.rf_we = 1; bus.data_imm = 1; bus.rf_mux = 1;
    go;
    check_rf("prio_r1", 1, 8'h5A);
    // sub wrap, then reserved mode must hold acc and flags
    op_imm(3'd7, 8'h00); op_imm(3'd1, 8'h01);
    check("sub_wrap_acc", bus.acc_out, 8'hFF);
    check_flags("sub_wrap", 0, 1);
    op_imm(3'd6, 8'h01);
    check("rsv_acc", bus.acc_out, 8'hFF);
    check_flags("rsv", 0, 1);
    // pass must not touch flags; idle cycles hold everything
    op_imm(3'd7, 8'h00);
    check("pass_acc", bus.acc_out, 8'h00);
    check_flags("pass", 0, 1);
    repeat (3) go;
    check("idle_acc", bus.acc_out, 8'h00);
    check_rf("idle_r3", 3, 8'h07);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
